// File: rtl/prog_clock_divider.sv
// ----------------------------------------------------------------------------
// prog_clock_divider
//
// Programmable integer clock divider. The active ratio N can be changed at
// run time. A new ratio is held as pending and takes effect only at a period
// boundary, so a period that has already started is never shortened.
// clk_out is high for ceil(N/2) input cycles and low for the rest.
//
// Parameters
//   CNT_W        width of the divide ratio and the counter
//   DEFAULT_DIV  ratio active after reset (2 .. 2^CNT_W-1)
//
// Ports
//   clk_in     system clock, rising edge
//   rst        asynchronous reset, active low
//   en         count enable; 0 freezes the divider
//   div_load   one-cycle request to load div_value as the next ratio
//   div_value  requested ratio, sampled when div_load is high
//   clk_out    divided clock, registered
//   tick       one-cycle strobe on each clk_out period boundary
//   busy       a loaded ratio is pending and not yet active
//   div_ack    one-cycle pulse on the edge a pending ratio becomes active
//   div_err    one-cycle pulse when a load is rejected (div_value < 2)
//   tick_cnt   16-bit free-running count of ticks
//              (present only when CLKDIV_TICK_CNT_EN is defined)
//
// Optional feature macro: CLKDIV_TICK_CNT_EN
// ----------------------------------------------------------------------------
module prog_clock_divider #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned DEFAULT_DIV = 2
) (
   input  logic             clk_in,
   input  logic             rst,
   input  logic             en,
   input  logic             div_load,
   input  logic [CNT_W-1:0] div_value,
   output logic             clk_out,
   output logic             tick,
   output logic             busy,
   output logic             div_ack,
   output logic             div_err
`ifdef CLKDIV_TICK_CNT_EN
   ,
   output logic [15:0]      tick_cnt
`endif
);

   localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
   localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(DEFAULT_DIV - 1);
   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

   logic [CNT_W-1:0] div_n;      // active ratio N
   logic [CNT_W-1:0] cnt;        // position inside the current period
   logic [CNT_W-1:0] pend_val;   // ratio waiting for the next wrap

   logic [CNT_W-1:0] n_last;
   logic [CNT_W-1:0] cnt_inc;
   logic [CNT_W-1:0] high_len;
   logic             wrap;
   logic             load_ok;
   logic             load_bad;

   always_comb begin
      n_last   = div_n - ONE;
      cnt_inc  = cnt + ONE;
      // ceil(N/2) without forming N+1, which could overflow CNT_W bits
      high_len = (div_n >> 1) + {{(CNT_W-1){1'b0}}, div_n[0]};
      wrap     = en && (cnt == n_last);
      load_ok  = div_load && (div_value >= TWO);
      load_bad = div_load && (div_value <  TWO);
   end

   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         div_n    <= DIV_RST;
         cnt      <= CNT_RST;
         pend_val <= '0;
         clk_out  <= 1'b0;
         tick     <= 1'b0;
         busy     <= 1'b0;
         div_ack  <= 1'b0;
         div_err  <= 1'b0;
      end else begin
         tick    <= 1'b0;
         div_ack <= 1'b0;
         div_err <= load_bad;

         if (en) begin
            if (wrap) begin
               cnt     <= '0;
               clk_out <= 1'b1;
               tick    <= 1'b1;
               if (busy) begin
                  div_n   <= pend_val;
                  div_ack <= 1'b1;
               end
            end else begin
               cnt     <= cnt_inc;
               clk_out <= (cnt_inc < high_len);
            end
         end

         // A load coinciding with a wrap: the old pending value is applied
         // above, the new one becomes pending and busy stays set.
         if (load_ok) begin
            pend_val <= div_value;
            busy     <= 1'b1;
         end else if (wrap) begin
            busy     <= 1'b0;
         end
      end
   end

`ifdef CLKDIV_TICK_CNT_EN
   always_ff @(posedge clk_in or negedge rst) begin
      if (!rst) begin
         tick_cnt <= '0;
      end else if (wrap) begin
         tick_cnt <= tick_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_prog_clock_divider.sv
// ----------------------------------------------------------------------------
// tb_prog_clock_divider
//
// Directed bench for prog_clock_divider (CNT_W=16, DEFAULT_DIV=2). A table of
// per-edge records {en, div_load, div_value, expected outputs} is applied one
// rising edge per record; hand-written sequences cover reset behaviour.
// Expected output vector order: {clk_out, tick, busy, div_ack, div_err}.
// ----------------------------------------------------------------------------
module tb_prog_clock_divider;

   logic        clk_in;
   logic        rst;
   logic        en;
   logic        div_load;
   logic [15:0] div_value;
   logic        clk_out;
   logic        tick;
   logic        busy;
   logic        div_ack;
   logic        div_err;
`ifdef CLKDIV_TICK_CNT_EN
   logic [15:0] tick_cnt;
`endif

   prog_clock_divider #(
      .CNT_W       (16),
      .DEFAULT_DIV (2)
   ) dut (
      .clk_in    (clk_in),
      .rst       (rst),
      .en        (en),
      .div_load  (div_load),
      .div_value (div_value),
      .clk_out   (clk_out),
      .tick      (tick),
      .busy      (busy),
      .div_ack   (div_ack),
      .div_err   (div_err)
`ifdef CLKDIV_TICK_CNT_EN
      ,
      .tick_cnt  (tick_cnt)
`endif
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   typedef struct {
      logic        en;
      logic        ld;
      logic [15:0] val;
      logic [4:0]  exp;
   } vec_t;

   vec_t        vecs[$];
   int unsigned checks = 0;
   int unsigned errors = 0;
   int unsigned exp_ticks = 0;

   task automatic add(input logic e, input logic l, input logic [15:0] v,
                      input logic c, input logic t, input logic b,
                      input logic a, input logic r);
      vec_t x;
      x.en  = e;
      x.ld  = l;
      x.val = v;
      x.exp = {c, t, b, a, r};
      vecs.push_back(x);
   endtask

   task automatic check(input string name, input logic [4:0] req);
      logic [4:0] act;
      act = {clk_out, tick, busy, div_ack, div_err};
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got {clk,tick,busy,ack,err}=%b required %b at %0t",
                  name, act, req, $time);
      end
   endtask

`ifdef CLKDIV_TICK_CNT_EN
   task automatic check_cnt(input string name, input logic [15:0] req);
      checks++;
      if (tick_cnt !== req) begin
         errors++;
         $display("FAIL %s: tick_cnt got %0d required %0d", name, tick_cnt, req);
      end
   endtask
`endif

   initial begin
      // Default N=2: 1,0,1,0,1 with ticks on edges 1,3,5
      add(1,0,0, 1,1,0,0,0);
      add(1,0,0, 0,0,0,0,0);
      add(1,0,0, 1,1,0,0,0);
      add(1,0,0, 0,0,0,0,0);
      add(1,0,0, 1,1,0,0,0);
      // Load 5 mid-period; applied at next wrap; high 3 / low 2
      add(1,1,5, 0,0,1,0,0);
      add(1,0,0, 1,1,0,1,0);
      add(1,0,0, 1,0,0,0,0);
      add(1,0,0, 1,0,0,0,0);
      add(1,0,0, 0,0,0,0,0);
      add(1,0,0, 0,0,0,0,0);
      add(1,0,0, 1,1,0,0,0);
      // Rejected loads of 1 and 0; N stays 5, busy stays 0
      add(1,1,1, 1,0,0,0,1);
      add(1,1,0, 1,0,0,0,1);
      add(1,0,0, 0,0,0,0,0);
      add(1,0,0, 0,0,0,0,0);
      add(1,0,0, 1,1,0,0,0);
      // Load 4 then 7 before the wrap: only 7 applies (high 4 / low 3)
      add(1,1,4, 1,0,1,0,0);
      add(1,1,7, 1,0,1,0,0);
      add(1,0,0, 0,0,1,0,0);
      add(1,0,0, 0,0,1,0,0);
      add(1,0,0, 1,1,0,1,0);
      add(1,0,0, 1,0,0,0,0);
      add(1,0,0, 1,0,0,0,0);
      add(1,0,0, 1,0,0,0,0);
      add(1,0,0, 0,0,0,0,0);
      add(1,0,0, 0,0,0,0,0);
      add(1,0,0, 0,0,0,0,0);
      add(1,0,0, 1,1,0,0,0);
      add(1,0,0, 1,0,0,0,0);
      // Freeze 10 cycles in the high phase; load 3 while frozen
      add(0,1,3, 1,0,1,0,0);
      for (int i = 0; i < 9; i++) add(0,0,0, 1,0,1,0,0);
      // Resume: remaining 2 high + 3 low cycles of the N=7 period
      add(1,0,0, 1,0,1,0,0);
      add(1,0,0, 1,0,1,0,0);
      add(1,0,0, 0,0,1,0,0);
      add(1,0,0, 0,0,1,0,0);
      add(1,0,0, 0,0,1,0,0);
      add(1,0,0, 1,1,0,1,0);
      // N=3: high 2 / low 1
      add(1,0,0, 1,0,0,0,0);
      add(1,0,0, 0,0,0,0,0);
      add(1,0,0, 1,1,0,0,0);
      // Load 6, then load 2 on the wrap edge that applies 6
      add(1,1,6, 1,0,1,0,0);
      add(1,0,0, 0,0,1,0,0);
      add(1,1,2, 1,1,1,1,0);
      add(1,0,0, 1,0,1,0,0);
      add(1,0,0, 1,0,1,0,0);
      add(1,0,0, 0,0,1,0,0);
      add(1,0,0, 0,0,1,0,0);
      add(1,0,0, 0,0,1,0,0);
      add(1,0,0, 1,1,0,1,0);
      add(1,0,0, 0,0,0,0,0);
      add(1,0,0, 1,1,0,0,0);
      // Leave clk_out high with 9 pending before the reset sequence
      add(1,0,0, 0,0,0,0,0);
      add(1,1,9, 1,1,1,0,0);

      rst       = 1'b0;
      en        = 1'b0;
      div_load  = 1'b0;
      div_value = '0;

      #2;
      check("reset_async", 5'b00000);
`ifdef CLKDIV_TICK_CNT_EN
      check_cnt("reset_tick_cnt", 16'd0);
`endif
      @(posedge clk_in); #1;
      check("reset_held", 5'b00000);

      @(negedge clk_in);
      rst = 1'b1;

      foreach (vecs[i]) begin
         en        = vecs[i].en;
         div_load  = vecs[i].ld;
         div_value = vecs[i].val;
         @(posedge clk_in); #1;
         if (vecs[i].exp[3]) exp_ticks++;
         check($sformatf("vec%0d", i), vecs[i].exp);
      end
      en       = 1'b1;
      div_load = 1'b0;
      div_value = '0;
`ifdef CLKDIV_TICK_CNT_EN
      check_cnt("tick_cnt_total", 16'(exp_ticks));
`endif

      // Asynchronous reset mid-period with 9 pending
      #3;
      rst = 1'b0;
      #1;
      check("midrun_reset_async", 5'b00000);
`ifdef CLKDIV_TICK_CNT_EN
      check_cnt("midrun_reset_tick_cnt", 16'd0);
`endif
      @(negedge clk_in);
      rst = 1'b1;
      // Pending 9 must be gone: N=2 again, no div_ack
      @(posedge clk_in); #1;
      check("post_reset_wrap", 5'b11000);
      @(posedge clk_in); #1;
      check("post_reset_low", 5'b00000);
      @(posedge clk_in); #1;
      check("post_reset_wrap2", 5'b11000);
      @(posedge clk_in); #1;
      check("post_reset_low2", 5'b00000);
`ifdef CLKDIV_TICK_CNT_EN
      check_cnt("post_reset_tick_cnt", 16'd2);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/prog_clock_divider.md
PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the divide-ratio and counter.
REQ-002 SHALL have parameter DEFAULT_DIV, default 2, ratio active after reset; legal range 2 .. 2^CNT_W-1.
REQ-003 SHALL have port clk_in  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port en  input  1  count enable; 0 freezes the divider.
REQ-006 SHALL have port div_load  input  1  one-cycle request to load a new ratio.
REQ-007 SHALL have port div_value  input  CNT_W  requested ratio N, sampled with div_load.
REQ-008 SHALL have port clk_out  output  1  divided clock, registered.
REQ-009 SHALL have port tick  output  1  one-cycle strobe on each clk_out rising period boundary.
REQ-010 SHALL have port busy  output  1  a loaded ratio is pending, not yet active.
REQ-011 SHALL have port div_ack  output  1  one-cycle pulse on the edge a pending ratio becomes active.
REQ-012 SHALL have port div_err  output  1  one-cycle pulse when a load is rejected.

Function
REQ-013 SHALL hold active ratio N, counter cnt (0..N-1), high time H = ceil(N/2).
REQ-014 SHALL, on an edge with en=1 and cnt=N-1: cnt<=0, clk_out<=1, tick<=1.
REQ-015 SHALL, on an edge with en=1 and cnt<N-1: cnt<=cnt+1, clk_out<=(cnt+1<H), tick<=0.
REQ-016 SHALL, with en=0: hold cnt and clk_out, drive tick=0.
REQ-017 SHALL produce period N clk_in cycles, high H cycles, low N-H cycles; N=2 toggles clk_out every edge.
REQ-018 SHALL accept div_load with div_value>=2 into a pending register, setting busy=1 on the next edge.
REQ-019 SHALL reject div_load with div_value<2: no state change, div_err=1 for one cycle.
REQ-020 SHALL let a later accepted load overwrite a pending value (last wins), busy stays 1.
REQ-021 SHALL apply a pending ratio only at a wrap (REQ-014 edge): N<=pending, busy<=0, div_ack<=1 on that edge.
REQ-022 SHALL, when div_load coincides with a wrap, apply any previously pending value at that wrap and make the new value pending for the next wrap.
REQ-023 SHALL accept loads while en=0; application still waits for a wrap.
REQ-024 SHALL never shorten or glitch a period in progress: ratio changes only at period boundaries.
REQ-025 SHALL compare and increment cnt in CNT_W bits without overflow (cnt never exceeds N-1).

Reset
REQ-026 SHALL, while rst=0 regardless of clock: clk_out=0, tick=0, busy=0, div_ack=0, div_err=0, N=DEFAULT_DIV, cnt=DEFAULT_DIV-1.
REQ-027 SHALL, on first enabled edge after release, wrap (clk_out=1, tick=1).
REQ-028 SHALL, on reset mid-period or with a load pending, discard cnt and the pending value.

Configuration
REQ-029 SHALL, with macro CLKDIV_TICK_CNT_EN defined, add output tick_cnt [15:0]: reset 0, +1 on each tick, wraps 0xFFFF->0x0000.
REQ-030 SHALL, without CLKDIV_TICK_CNT_EN, omit tick_cnt and its logic; all other behaviour identical.

Verification
REQ-031 SHALL cover: reset release, en=1, default N=2 -> clk_out 1,0,1,0 on successive edges, tick on edges 1,3,5.
REQ-032 SHALL cover: load 5 mid-period -> busy=1 until the next wrap, div_ack then; clk_out high 3, low 2 cycles thereafter.
REQ-033 SHALL cover: load 1 and load 0 -> div_err pulse each, N and busy unchanged.
REQ-034 SHALL cover: load 4 then load 7 before a wrap -> only 7 applied, one div_ack.
REQ-035 SHALL cover: en=0 for 10 cycles mid-high-phase -> clk_out and cnt frozen, tick=0, resumes seamlessly.
REQ-036 SHALL cover: rst=0 asynchronously mid-period with load pending -> outputs zero immediately, pending discarded, tick_cnt=0 when CLKDIV_TICK_CNT_EN defined.
